// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_controller
// Brief    : Mode-0 SPI master that serialises 16-bit {rw, addr, data} command
//            frames MSB-first with programmable SCLK divider and CS gap.
// Revision : 1.0 - initial release
// ============================================================================
module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       spi_sclk,
  output logic       spi_copi,
  output logic       spi_nCS
);

  localparam int c_CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_div,   w_div_nxt;
  logic [3:0]           r_bit,   w_bit_nxt;
  logic                 r_last,  w_last_nxt;
  logic [15:0]          r_shreg, w_shreg_nxt;
  logic                 r_sclk,  w_sclk_nxt;
  logic                 r_copi,  w_copi_nxt;
  logic                 r_ncs,   w_ncs_nxt;
  logic                 r_done,  w_done_nxt;
  logic                 w_div_end;

  assign w_div_end = (r_div == c_DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_last  <= 1'b0;
      r_shreg <= '0;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ncs   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_last  <= w_last_nxt;
      r_shreg <= w_shreg_nxt;
      r_sclk  <= w_sclk_nxt;
      r_copi  <= w_copi_nxt;
      r_ncs   <= w_ncs_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic also computes the next value of every registered output,
  // so the pins change on the same edge as the state they belong to.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div + c_CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_last_nxt  = r_last;
    w_shreg_nxt = r_shreg;
    w_sclk_nxt  = r_sclk;
    w_copi_nxt  = r_copi;
    w_ncs_nxt   = r_ncs;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        if (cmd_valid) begin
          w_state_nxt = S_SETUP;
          w_shreg_nxt = {cmd_rw, cmd_addr, cmd_data};
          w_copi_nxt  = cmd_rw;
          w_ncs_nxt   = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_bit_nxt   = 4'd15;
          w_last_nxt  = 1'b0;
        end
      end

      S_SETUP: begin
        w_copi_nxt = r_shreg[15];
        if (w_div_end) begin
          w_state_nxt = S_SHIFT_HI;
          w_div_nxt   = '0;
          w_sclk_nxt  = 1'b1;
        end
      end

      S_SHIFT_HI: begin
        if (w_div_end) begin
          w_state_nxt = S_SHIFT_LO;
          w_div_nxt   = '0;
          w_sclk_nxt  = 1'b0;
          w_shreg_nxt = {r_shreg[14:0], 1'b0};
          w_copi_nxt  = r_shreg[14];
          // Counter saturates at zero; the flag marks the 16th bit's low phase.
          if (r_bit == 4'd0) begin
            w_last_nxt = 1'b1;
          end else begin
            w_bit_nxt = r_bit - 4'd1;
          end
        end
      end

      S_SHIFT_LO: begin
        if (w_div_end) begin
          w_div_nxt = '0;
          if (r_last) begin
            w_state_nxt = S_GAP;
            w_ncs_nxt   = 1'b1;
            w_copi_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_SHIFT_HI;
            w_sclk_nxt  = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (r_div == c_GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
          w_last_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_div_nxt   = '0;
        w_sclk_nxt  = 1'b0;
        w_ncs_nxt   = 1'b1;
      end
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign spi_sclk  = r_sclk;
  assign spi_copi  = r_copi;
  assign spi_nCS   = r_ncs;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_controller
// Brief    : Directed bench: deserialises the SPI pins and checks frames,
//            timing, reset behaviour and a loopback register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_ready, busy, done, spi_sclk, spi_copi, spi_nCS;

  logic       v2, rw2;
  logic [6:0] addr2;
  logic [7:0] data2;
  logic       ready2, busy2, done2, sclk2, copi2, ncs2;

  always #5 clk = ~clk;

  spi_controller dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .busy(busy), .done(done), .spi_sclk(spi_sclk), .spi_copi(spi_copi),
    .spi_nCS(spi_nCS)
  );

  spi_controller #(.CLK_DIV(2), .CS_GAP(4)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(ready2),
    .cmd_rw(rw2), .cmd_addr(addr2), .cmd_data(data2),
    .busy(busy2), .done(done2), .spi_sclk(sclk2), .spi_copi(copi2),
    .spi_nCS(ncs2)
  );

  int checks = 0;
  int errors = 0;

  // Monitor for the default-parameter instance, sampled on the falling edge.
  int          ncyc = 0;
  logic        p_sclk = 1'b0, p_ncs = 1'b1;
  logic [15:0] m_cap = '0;
  int          m_edges = 0, m_low = 0, m_hi = 0, m_done = 0, m_bad_edges = 0;
  int          m_low_len = 0, m_hi_len = 0, m_first_rise = 0;
  logic [15:0] q[$];
  int          q_edges[$];

  always @(negedge clk) begin
    ncyc++;
    if (done === 1'b1) m_done++;
    if (spi_sclk === 1'b1 && p_sclk === 1'b0) begin
      if (spi_nCS !== 1'b0) m_bad_edges++;
      else begin
        if (m_edges == 0) m_first_rise = ncyc;
        m_cap = {m_cap[14:0], spi_copi};
        m_edges++;
      end
    end
    if (spi_nCS === 1'b0) m_low++; else m_hi++;
    if (spi_nCS === 1'b0 && p_ncs === 1'b1) begin
      m_hi_len = m_hi;
      m_hi     = 0;
    end
    if (spi_nCS === 1'b1 && p_ncs === 1'b0) begin
      m_low_len = m_low;
      m_low     = 0;
      q.push_back(m_cap);
      q_edges.push_back(m_edges);
      m_edges = 0;
      m_cap   = '0;
    end
    p_sclk = spi_sclk;
    p_ncs  = spi_nCS;
  end

  // Second monitor feeds a stand-in for the register peripheral (regs 0x00/0x02/0x04).
  logic        p2_sclk = 1'b0, p2_ncs = 1'b1;
  logic [15:0] m2_cap = '0;
  int          m2_edges = 0, m2_low = 0, m2_low_len = 0;
  logic [15:0] q2[$];
  logic [7:0]  pr0 = '0, pr2 = '0, pr4 = '0;

  always @(negedge clk) begin
    if (sclk2 === 1'b1 && p2_sclk === 1'b0 && ncs2 === 1'b0) begin
      m2_cap = {m2_cap[14:0], copi2};
      m2_edges++;
    end
    if (ncs2 === 1'b0) m2_low++;
    if (ncs2 === 1'b1 && p2_ncs === 1'b0) begin
      m2_low_len = m2_low;
      m2_low     = 0;
      q2.push_back(m2_cap);
      if (m2_edges == 16 && m2_cap[15]) begin
        case (m2_cap[14:8])
          7'h00:   pr0 = m2_cap[7:0];
          7'h02:   pr2 = m2_cap[7:0];
          7'h04:   pr4 = m2_cap[7:0];
          default: ;
        endcase
      end
      m2_edges = 0;
      m2_cap   = '0;
    end
    p2_sclk = sclk2;
    p2_ncs  = ncs2;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic rw,
                       input logic [6:0] a, input logic [7:0] d);
    if (sel) begin v2 = v; rw2 = rw; addr2 = a; data2 = d; end
    else begin cmd_valid = v; cmd_rw = rw; cmd_addr = a; cmd_data = d; end
  endtask

  // Presents a command and returns the sample index of the acceptance cycle.
  task automatic send(input bit sel, input logic rw, input logic [6:0] a,
                      input logic [7:0] d, input bit hold, output int acc);
    acc = -1;
    drive(sel, 1'b1, rw, a, d);
    for (int k = 0; k < 400; k++) begin
      if ((sel ? ready2 : cmd_ready) === 1'b1) begin
        acc = ncyc;
        break;
      end
      tick();
    end
    if (acc < 0) check("accept_timeout", 32'd1, 32'd0);
    tick();
    if (!hold) begin
      if (sel) v2 = 1'b0; else cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input bit sel, output int idx);
    idx = -1;
    for (int k = 0; k < 400; k++) begin
      if ((sel ? ready2 : cmd_ready) === 1'b1) begin
        idx = ncyc;
        break;
      end
      tick();
    end
    if (idx < 0) check("ready_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [15:0] pop_frame();
    logic [15:0] f;
    f = 16'hDEAD;
    if (q.size() > 0) begin
      f = q.pop_front();
      void'(q_edges.pop_front());
    end
    return f;
  endfunction

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t        vt[4];
    int          acc, acc2, rdy, d0, act, e;
    logic [15:0] f;

    vt[0] = '{1'b1, 7'h04, 8'h80, 16'h8480};
    vt[1] = '{1'b0, 7'h00, 8'h00, 16'h0000};
    vt[2] = '{1'b0, 7'h7F, 8'hFF, 16'h7FFF};
    vt[3] = '{1'b1, 7'h2A, 8'h55, 16'hAA55};

    // Reset with cmd_valid asserted: the request must be ignored.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 7'h01, 8'h01);
    drive(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
    repeat (3) tick();
    check("rst_ncs_held", {31'd0, spi_nCS}, 32'd1);
    rst = 1'b0;
    cmd_valid = 1'b0;
    tick();
    check("rst_ncs",   {31'd0, spi_nCS},   32'd1);
    check("rst_sclk",  {31'd0, spi_sclk},  32'd0);
    check("rst_copi",  {31'd0, spi_copi},  32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    act = 0;
    for (int k = 0; k < 20; k++) begin
      if (spi_sclk !== 1'b0 || spi_nCS !== 1'b1) act++;
      tick();
    end
    check("idle_activity", act, 0);
    check("idle_frames", q.size(), 0);

    // Table-driven single frames with full timing checks.
    for (int i = 0; i < 4; i++) begin
      d0 = m_done;
      send(1'b0, vt[i].rw, vt[i].addr, vt[i].data, 1'b0, acc);
      wait_ready(1'b0, rdy);
      check("vec_nframes", q.size(), 1);
      e = (q_edges.size() > 0) ? q_edges[0] : -1;
      check("vec_edges", e, 16);
      f = pop_frame();
      check("vec_frame", {16'd0, f}, {16'd0, vt[i].exp});
      check("vec_ncs_low", m_low_len, 132);
      check("vec_ready_lat", rdy - acc, 137);
      check("vec_first_rise", m_first_rise - acc, 5);
      check("vec_done_pulses", m_done - d0, 1);
    end
    check("no_edge_while_cs_high", m_bad_edges, 0);

    // Input changes and a stray cmd_valid pulse while busy.
    send(1'b0, 1'b1, 7'h10, 8'h33, 1'b0, acc);
    repeat (40) tick();
    drive(1'b0, 1'b1, 1'b1, 7'h7F, 8'hFF);
    tick();
    cmd_valid = 1'b0;
    wait_ready(1'b0, rdy);
    repeat (20) tick();
    check("stab_nframes", q.size(), 1);
    f = pop_frame();
    check("stab_frame", {16'd0, f}, 32'h9033);
    check("stab_idle_ncs", {31'd0, spi_nCS}, 32'd1);

    // Back-to-back with cmd_valid held high.
    send(1'b0, 1'b1, 7'h00, 8'h01, 1'b1, acc);
    send(1'b0, 1'b1, 7'h01, 8'hF0, 1'b0, acc2);
    wait_ready(1'b0, rdy);
    check("b2b_nframes", q.size(), 2);
    f = pop_frame();
    check("b2b_frame0", {16'd0, f}, 32'h8001);
    f = pop_frame();
    check("b2b_frame1", {16'd0, f}, 32'h81F0);
    check("b2b_cs_gap", m_hi_len, 5);
    check("b2b_accept_spacing", acc2 - acc, 137);

    // Reset after the 7th rising SCLK edge.
    d0 = m_done;
    send(1'b0, 1'b1, 7'h12, 8'h34, 1'b0, acc);
    e = 0;
    for (int k = 0; k < 400 && m_edges < 7; k++) begin
      tick();
      e++;
    end
    check("mid_reach_edge7", m_edges, 7);
    rst = 1'b1;
    tick();
    check("mid_ncs",   {31'd0, spi_nCS},   32'd1);
    check("mid_sclk",  {31'd0, spi_sclk},  32'd0);
    check("mid_done",  {31'd0, done},      32'd0);
    check("mid_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    repeat (10) tick();
    check("mid_no_done", m_done - d0, 0);
    q.delete();
    q_edges.delete();
    send(1'b0, 1'b1, 7'h02, 8'h55, 1'b0, acc);
    wait_ready(1'b0, rdy);
    check("post_rst_nframes", q.size(), 1);
    f = pop_frame();
    check("post_rst_frame", {16'd0, f}, 32'h8255);
    check("post_rst_done", m_done - d0, 1);

    // Loopback at CLK_DIV=2 into the register model.
    send(1'b1, 1'b1, 7'h00, 8'hA5, 1'b0, acc);
    wait_ready(1'b1, rdy);
    check("lb_ready_lat", rdy - acc, 71);
    send(1'b1, 1'b1, 7'h02, 8'h3C, 1'b0, acc);
    wait_ready(1'b1, rdy);
    send(1'b1, 1'b1, 7'h04, 8'h80, 1'b0, acc);
    wait_ready(1'b1, rdy);
    send(1'b1, 1'b0, 7'h04, 8'h12, 1'b0, acc);
    wait_ready(1'b1, rdy);
    check("lb_ncs_low", m2_low_len, 66);
    check("lb_nframes", q2.size(), 4);
    check("lb_reg0", {24'd0, pr0}, 32'hA5);
    check("lb_reg2", {24'd0, pr2}, 32'h3C);
    check("lb_reg4_after_read", {24'd0, pr4}, 32'h80);
    send(1'b1, 1'b1, 7'h15, 8'h11, 1'b0, acc);
    wait_ready(1'b1, rdy);
    check("lb_inv_frame", {16'd0, (q2.size() > 0) ? q2[q2.size()-1] : 16'hDEAD}, 32'h9511);
    check("lb_inv_reg0", {24'd0, pr0}, 32'hA5);
    check("lb_inv_reg2", {24'd0, pr2}, 32'h3C);
    check("lb_inv_reg4", {24'd0, pr4}, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
